// File: rtl/alu_exec_unit.sv
// alu_exec_unit: RISC-V style ALU execute stage with a valid/ready handshake.
// Decodes aluop/funct3/funct7b5 into an ALU select, computes the result and
// holds it in a DONE state until the consumer takes it.
// Build option: define ALU_EXEC_FAST_SHIFT_EN to replace the serial one-bit-per-
// cycle shifter with a single-cycle barrel shifter (SHIFT state then unused).
module alu_exec_unit #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      aluop,
    input  logic [2:0]      funct3,
    input  logic            funct7b5,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            in_valid,
    output logic            in_ready,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic [3:0]      alu_sel,
    output logic            zero,
    output logic            illegal
);

    localparam logic [3:0] SEL_AND  = 4'b0000;
    localparam logic [3:0] SEL_OR   = 4'b0001;
    localparam logic [3:0] SEL_ADD  = 4'b0010;
    localparam logic [3:0] SEL_XOR  = 4'b0011;
    localparam logic [3:0] SEL_SLL  = 4'b0100;
    localparam logic [3:0] SEL_SRL  = 4'b0101;
    localparam logic [3:0] SEL_SUB  = 4'b0110;
    localparam logic [3:0] SEL_SRA  = 4'b0111;
    localparam logic [3:0] SEL_SLT  = 4'b1000;
    localparam logic [3:0] SEL_SLTU = 4'b1001;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t          state_q;
    logic [XLEN-1:0] result_q;
    logic [3:0]      aluSel_q;
    logic            zero_q;
    logic            illegal_q;
`ifndef ALU_EXEC_FAST_SHIFT_EN
    logic [SHW-1:0]  count_q;
    logic            isShift_d;
`endif

    logic [3:0]      sel_d;
    logic            illegal_d;
    logic [XLEN-1:0] value_d;
    logic [SHW-1:0]  shamt;

    assign shamt = op_b[SHW-1:0];

    // Decode instruction class and function fields into an ALU select; flag
    // encodings that have no legal meaning and fall back to a harmless ADD.
    always_comb begin
        sel_d     = SEL_ADD;
        illegal_d = 1'b0;
        case (aluop)
            2'b00: sel_d = SEL_ADD;
            2'b01: sel_d = SEL_SUB;
            default: begin
                case (funct3)
                    3'b000:  sel_d = (aluop == 2'b10 && funct7b5) ? SEL_SUB : SEL_ADD;
                    3'b001:  sel_d = SEL_SLL;
                    3'b010:  sel_d = SEL_SLT;
                    3'b011:  sel_d = SEL_SLTU;
                    3'b100:  sel_d = SEL_XOR;
                    3'b101:  sel_d = funct7b5 ? SEL_SRA : SEL_SRL;
                    3'b110:  sel_d = SEL_OR;
                    default: sel_d = SEL_AND;
                endcase
                if (funct7b5 && (funct3 == 3'b001 ||
                    (aluop == 2'b10 && funct3 != 3'b000 && funct3 != 3'b101))) begin
                    illegal_d = 1'b1;
                    sel_d     = SEL_ADD;
                end
            end
        endcase
    end

    // Single-cycle datapath; illegal operations produce a zero result.
    always_comb begin
        value_d = '0;
        case (sel_d)
            SEL_ADD:  value_d = op_a + op_b;
            SEL_SUB:  value_d = op_a - op_b;
            SEL_AND:  value_d = op_a & op_b;
            SEL_OR:   value_d = op_a | op_b;
            SEL_XOR:  value_d = op_a ^ op_b;
            SEL_SLT:  value_d = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            SEL_SLTU: value_d = {{(XLEN-1){1'b0}}, (op_a < op_b)};
`ifdef ALU_EXEC_FAST_SHIFT_EN
            SEL_SLL:  value_d = op_a << shamt;
            SEL_SRL:  value_d = op_a >> shamt;
            SEL_SRA:  value_d = $unsigned($signed(op_a) >>> shamt);
`endif
            default:  value_d = '0;
        endcase
        if (illegal_d) begin
            value_d = '0;
        end
    end

`ifndef ALU_EXEC_FAST_SHIFT_EN
    // Shifts are routed to the serial shifter instead of the datapath.
    always_comb begin
        isShift_d = (sel_d == SEL_SLL) || (sel_d == SEL_SRL) || (sel_d == SEL_SRA);
    end
`endif

    // Handshake FSM: accept in IDLE, optionally shift serially, hold in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            result_q  <= '0;
            aluSel_q  <= SEL_ADD;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
`ifndef ALU_EXEC_FAST_SHIFT_EN
            count_q   <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        aluSel_q  <= sel_d;
                        illegal_q <= illegal_d;
`ifdef ALU_EXEC_FAST_SHIFT_EN
                        result_q  <= value_d;
                        zero_q    <= (value_d == '0);
                        state_q   <= DONE;
`else
                        if (isShift_d) begin
                            result_q <= op_a;
                            count_q  <= shamt;
                            zero_q   <= 1'b0;
                            state_q  <= SHIFT;
                        end else begin
                            result_q <= value_d;
                            zero_q   <= (value_d == '0);
                            state_q  <= DONE;
                        end
`endif
                    end
                end
`ifndef ALU_EXEC_FAST_SHIFT_EN
                SHIFT: begin
                    if (count_q == '0) begin
                        zero_q  <= (result_q == '0);
                        state_q <= DONE;
                    end else begin
                        case (aluSel_q)
                            SEL_SLL: result_q <= result_q << 1;
                            SEL_SRL: result_q <= result_q >> 1;
                            default: result_q <= {result_q[XLEN-1], result_q[XLEN-1:1]};
                        endcase
                        count_q <= count_q - SHW'(1);
                    end
                end
`endif
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign alu_sel   = aluSel_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed-vector bench for alu_exec_unit (XLEN=32).
// Covers decode, arithmetic, serial/fast shift latency, output hold under
// back-pressure and asynchronous reset during an operation.
module tb_alu_exec_unit;

    localparam int XLEN = 32;
    localparam int WAIT_LIMIT = 100;

    logic            clk;
    logic            rst_n;
    logic [1:0]      aluop;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            in_valid;
    logic            in_ready;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic [3:0]      alu_sel;
    logic            zero;
    logic            illegal;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    alu_exec_unit #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .aluop     (aluop),
        .funct3    (funct3),
        .funct7b5  (funct7b5),
        .op_a      (op_a),
        .op_b      (op_b),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .alu_sel   (alu_sel),
        .zero      (zero),
        .illegal   (illegal)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [1:0]  aluop;
        logic [2:0]  f3;
        logic        f7;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  sel;
        logic        ill;
        logic [7:0]  serialWait;
    } vec_t;

    // serialWait: clock edges after the accepting edge until out_valid with the
    // serial shifter (shamt+1 for shifts, 0 otherwise).
    localparam int NVEC = 19;
    vec_t vectors [NVEC] = '{
        '{2'b10, 3'b000, 1'b1, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 4'b0110, 1'b0, 8'd0},
        '{2'b10, 3'b101, 1'b1, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 4'b0111, 1'b0, 8'd5},
        '{2'b10, 3'b111, 1'b1, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 4'b0010, 1'b1, 8'd0},
        '{2'b10, 3'b010, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 4'b1000, 1'b0, 8'd0},
        '{2'b10, 3'b011, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b1001, 1'b0, 8'd0},
        '{2'b00, 3'b111, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b0010, 1'b0, 8'd0},
        '{2'b01, 3'b111, 1'b1, 32'h0000_000A, 32'h0000_000A, 32'h0000_0000, 4'b0110, 1'b0, 8'd0},
        '{2'b11, 3'b000, 1'b1, 32'h0000_0005, 32'h0000_0007, 32'h0000_000C, 4'b0010, 1'b0, 8'd0},
        '{2'b11, 3'b001, 1'b1, 32'h0000_0001, 32'h0000_0003, 32'h0000_0000, 4'b0010, 1'b1, 8'd0},
        '{2'b11, 3'b101, 1'b0, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 4'b0101, 1'b0, 8'd5},
        '{2'b10, 3'b001, 1'b0, 32'h0000_0001, 32'h0000_0000, 32'h0000_0001, 4'b0100, 1'b0, 8'd1},
        '{2'b11, 3'b100, 1'b1, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, 4'b0011, 1'b0, 8'd0},
        '{2'b10, 3'b110, 1'b0, 32'hF0F0_0000, 32'h0000_F0F0, 32'hF0F0_F0F0, 4'b0001, 1'b0, 8'd0},
        '{2'b10, 3'b111, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 4'b0000, 1'b0, 8'd0},
        '{2'b10, 3'b010, 1'b0, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 4'b1000, 1'b0, 8'd0},
        '{2'b10, 3'b101, 1'b0, 32'hFFFF_FFFF, 32'h0000_0023, 32'h1FFF_FFFF, 4'b0101, 1'b0, 8'd4},
        '{2'b10, 3'b100, 1'b1, 32'h0000_00FF, 32'h0000_0001, 32'h0000_0000, 4'b0010, 1'b1, 8'd0},
        '{2'b10, 3'b101, 1'b1, 32'h4000_0000, 32'h0000_0002, 32'h1000_0000, 4'b0111, 1'b0, 8'd3},
        '{2'b10, 3'b001, 1'b0, 32'h0000_0003, 32'h0000_0008, 32'h0000_0300, 4'b0100, 1'b0, 8'd9}
    };

    // Count one comparison and report it when observed differs from expected.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end else begin
            passCount++;
        end
    endtask

    // Present one request at a falling edge and let it be accepted at the next rising edge.
    task automatic applyStimulus(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                                 input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        checkOutput("inReadyBeforeAccept", {63'd0, in_ready}, 64'd1);
        aluop    = op;
        funct3   = f3;
        funct7b5 = f7;
        op_a     = a;
        op_b     = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Count rising edges after acceptance until out_valid, bounded by WAIT_LIMIT.
    task automatic waitResult(output int waited);
        waited = 0;
        while (!out_valid && waited < WAIT_LIMIT) begin
            @(posedge clk);
            #1;
            waited++;
        end
    endtask

    // Hand the result to the consumer and confirm the unit is idle again.
    task automatic releaseResult();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput("inReadyAfterTake", {63'd0, in_ready}, 64'd1);
        checkOutput("outValidAfterTake", {63'd0, out_valid}, 64'd0);
    endtask

    initial begin
        int waited;
        int expWait;

        rst_n     = 1'b0;
        aluop     = 2'b00;
        funct3    = 3'b000;
        funct7b5  = 1'b0;
        op_a      = '0;
        op_b      = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;

        // Reset values while held in reset
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rstResult", {32'd0, result}, 64'd0);
        checkOutput("rstAluSel", {60'd0, alu_sel}, 64'h2);
        checkOutput("rstZero", {63'd0, zero}, 64'd0);
        checkOutput("rstIllegal", {63'd0, illegal}, 64'd0);
        checkOutput("rstOutValid", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("inReadyAfterRst", {63'd0, in_ready}, 64'd1);

        // Directed vectors through the full handshake
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vectors[i].aluop, vectors[i].f3, vectors[i].f7,
                          vectors[i].a, vectors[i].b);
`ifdef ALU_EXEC_FAST_SHIFT_EN
            expWait = 0;
`else
            expWait = int'(vectors[i].serialWait);
`endif
            waitResult(waited);
            checkOutput($sformatf("v%0d_wait", i), 64'(waited), 64'(expWait));
            checkOutput($sformatf("v%0d_outValid", i), {63'd0, out_valid}, 64'd1);
            checkOutput($sformatf("v%0d_result", i), {32'd0, result}, {32'd0, vectors[i].res});
            checkOutput($sformatf("v%0d_aluSel", i), {60'd0, alu_sel}, {60'd0, vectors[i].sel});
            checkOutput($sformatf("v%0d_zero", i), {63'd0, zero},
                        {63'd0, (vectors[i].res == 32'd0)});
            checkOutput($sformatf("v%0d_illegal", i), {63'd0, illegal}, {63'd0, vectors[i].ill});
            releaseResult();
        end

        // Back-pressure: result holds while out_ready is low, new requests ignored
        applyStimulus(2'b00, 3'b000, 1'b0, 32'd3, 32'd4);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            aluop    = 2'b01;
            op_a     = 32'd100;
            op_b     = 32'd1;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            checkOutput($sformatf("holdResult%0d", c), {32'd0, result}, 64'd7);
            checkOutput($sformatf("holdInReady%0d", c), {63'd0, in_ready}, 64'd0);
            checkOutput($sformatf("holdOutValid%0d", c), {63'd0, out_valid}, 64'd1);
            checkOutput($sformatf("holdAluSel%0d", c), {60'd0, alu_sel}, 64'h2);
        end
        @(negedge clk);
        in_valid = 1'b0;
        releaseResult();
        @(posedge clk);
        #1;
        checkOutput("ignoredReqNotRun", {63'd0, out_valid}, 64'd0);

        // Asynchronous reset in the middle of a long shift
        applyStimulus(2'b10, 3'b001, 1'b0, 32'd1, 32'd31);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midRstOutValid", {63'd0, out_valid}, 64'd0);
        checkOutput("midRstResult", {32'd0, result}, 64'd0);
        checkOutput("midRstInReady", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("postRstInReady", {63'd0, in_ready}, 64'd1);
        checkOutput("postRstOutValid", {63'd0, out_valid}, 64'd0);

        // A fresh operation works after the reset
        applyStimulus(2'b00, 3'b000, 1'b0, 32'd20, 32'd22);
        waitResult(waited);
        checkOutput("postRstAddWait", 64'(waited), 64'd0);
        checkOutput("postRstAddResult", {32'd0, result}, 64'd42);
        releaseResult();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width; legal values 8, 16, 32, 64.
REQ-002 SHALL have parameter SHW, default $clog2(XLEN), shift-amount width taken from op_b[SHW-1:0].
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port aluop  input  2  class: 00 load/store add, 01 branch sub, 10 R-type, 11 I-type.
REQ-006 SHALL have port funct3  input  3  instruction bits [14:12].
REQ-007 SHALL have port funct7b5  input  1  instruction bit 30.
REQ-008 SHALL have ports op_a, op_b  input  XLEN  operands.
REQ-009 SHALL have port in_valid  input  1  request strobe; in_ready  output  1  unit can accept.
REQ-010 SHALL have port out_valid  output  1  result available; out_ready  input  1  consumer takes result.
REQ-011 SHALL have ports result  output  XLEN, alu_sel  output  4, zero  output  1 (result==0), illegal  output  1.

Function
REQ-012 Decode SHALL give alu_sel: ADD 0010, SUB 0110, AND 0000, OR 0001, XOR 0011, SLL 0100, SRL 0101, SRA 0111, SLT 1000, SLTU 1001.
REQ-013 aluop 00 -> ADD; 01 -> SUB; funct3/funct7b5 ignored.
REQ-014 aluop 10: funct3 000 -> ADD (f7b5=0) / SUB (1); 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRL (0) / SRA (1); 110 OR; 111 AND.
REQ-015 aluop 11: as 10 except funct3 000 always ADD; funct7b5 honoured only for funct3 101.
REQ-016 aluop 10 with funct7b5=1 and funct3 not in {000,101}, or funct3 001 with funct7b5=1 in either class, SHALL set illegal=1, alu_sel=0010, result=0.
REQ-017 FSM states IDLE, SHIFT, DONE; in_ready=1 only in IDLE; accept = in_valid & in_ready.
REQ-018 On accept of a non-shift op: compute, register result/alu_sel/zero/illegal, go to DONE; out_valid=1 on the next cycle (latency 1).
REQ-019 On accept of a shift: load op_a into shift register, counter=op_b[SHW-1:0], go to SHIFT.
REQ-020 In SHIFT: counter==0 -> DONE; else shift 1 bit (SRA replicates MSB), counter decrements; latency = shamt+1 cycles.
REQ-021 In DONE: out_valid=1; outputs SHALL hold stable until out_ready=1, then IDLE the following cycle.
REQ-022 Arithmetic SHALL be modulo 2^XLEN; SLT signed, SLTU unsigned, result 1 or 0 zero-extended.
REQ-023 Inputs in non-IDLE states SHALL be ignored; in_valid while busy is not an error.

Reset
REQ-024 rst_n=0 SHALL force IDLE immediately, asynchronously, including mid-SHIFT or DONE; pending op discarded.
REQ-025 Reset values: result=0, alu_sel=0010, zero=0, illegal=0, out_valid=0, counter=0; in_ready=1 after release.

Configuration
REQ-026 Macro ALU_EXEC_FAST_SHIFT_EN defined: shifts use a barrel shifter, latency 1 like all ops, SHIFT state unused.
REQ-027 Macro undefined: serial shifter per REQ-019..020; decode, handshake and outputs otherwise identical.

Verification
REQ-028 aluop=10, f3=000, f7b5=1, a=5, b=7 -> one cycle later out_valid=1, result=FFFFFFFE, alu_sel=0110, zero=0.
REQ-029 aluop=10, f3=101, f7b5=1, a=80000000, b=4 -> serial: out_valid after 5 cycles, result=F8000000, alu_sel=0111; fast: after 1 cycle.
REQ-030 aluop=10, f3=111, f7b5=1 -> illegal=1, result=0, alu_sel=0010, zero=1 (result==0).
REQ-031 ADD a=3, b=4 accepted, out_ready=0 for 3 cycles -> result=7 held, in_ready=0, second in_valid ignored; out_ready=1 -> IDLE next cycle.
REQ-032 SLL b=31 started, rst_n pulsed low at cycle 10 -> out_valid=0, result=0 immediately; in_ready=1 after release.
REQ-033 aluop=10, f3=010 vs 011, a=FFFFFFFF, b=1 -> SLT result=1, SLTU result=0.
